// File: rtl/alu_pkg.sv
// alu_pkg: operation codes, FSM states and op classification helpers for alu_md.
package alu_pkg;
  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MULU = 3'b011;
  localparam logic [2:0] OP_DIVU = 3'b100;
  localparam logic [2:0] OP_REMU = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic logic is_div(input logic [2:0] op);
    return op == OP_DIVU || op == OP_REMU;
  endfunction
  function automatic logic is_iter(input logic [2:0] op);
    return op == OP_MULU || is_div(op);
  endfunction
endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle shift-add multiplier and restoring divider.
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             div,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic run_q, run_d, div_q, div_d, ge;
  logic [WIDTH:0] sh, rem;
  always_comb begin
    sh    = {acc_q, a_q[WIDTH-1]};
    ge    = sh >= {1'b0, b_q};
    rem   = ge ? sh - {1'b0, b_q} : sh;
    a_d   = start ? srca : run_q ? a_q << 1 : a_q;
    b_d   = start ? srcb : (run_q && !div_q) ? b_q >> 1 : b_q;
    acc_d = start ? '0 : !run_q ? acc_q : div_q ? rem[WIDTH-1:0] : acc_q + (b_q[0] ? a_q : '0);
    q_d   = start ? '0 : (run_q && div_q) ? {q_q[WIDTH-2:0], ge} : q_q;
    cnt_d = start ? '0 : run_q ? cnt_q + 1'b1 : cnt_q;
    done  = run_q && cnt_q == CW'(WIDTH - 1);
    run_d = start || (run_q && !done);
    div_d = start ? div : div_q;
  end
  // Results are the values being written on the final step, so the FSM can capture them on done.
  assign product   = acc_d;
  assign remainder = acc_d;
  assign quotient  = q_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      q_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      div_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      q_q   <= q_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
      div_q <= div_d;
    end
  end
endmodule

// File: rtl/alu_md.sv
// alu_md: handshaked ALU with single-cycle logic/arith ops and iterative MULU/DIVU/REMU.
module alu_md
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [2:0]       aluctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluresult,
  output logic             zero,
  output logic             divzero,
  output logic             busy
);
  state_t state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d, single, product, quotient, remainder;
  logic [2:0] op_q, op_d;
  logic dz_q, dz_d, start, done, bz;
  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk(clk), .reset(reset), .start(start), .div(is_div(aluctrl)),
    .srca(srca), .srcb(srcb), .done(done),
    .product(product), .quotient(quotient), .remainder(remainder)
  );
  // Divide-by-zero results are produced here directly instead of running the iterator.
  always_comb begin
    bz     = srcb == '0;
    single = aluctrl == OP_AND ? srca & srcb :
             aluctrl == OP_OR  ? srca | srcb :
             aluctrl == OP_ADD ? srca + srcb :
             aluctrl == OP_SUB ? srca - srcb :
             aluctrl == OP_SLT ? WIDTH'(srca < srcb) :
             aluctrl == OP_DIVU ? '1 : srca;
    state_d = state_q;
    res_d   = res_q;
    dz_d    = dz_q;
    op_d    = op_q;
    start   = 1'b0;
    case (state_q)
      IDLE: if (in_valid) begin
        op_d = aluctrl;
        dz_d = is_div(aluctrl) && bz;
        if (is_iter(aluctrl) && !(is_div(aluctrl) && bz)) begin
          start   = 1'b1;
          state_d = BUSY;
        end else begin
          res_d   = single;
          state_d = DONE;
        end
      end
      BUSY: if (done) begin
        res_d   = op_q == OP_REMU ? remainder : op_q == OP_DIVU ? quotient : product;
        state_d = DONE;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      res_q   <= '0;
      dz_q    <= 1'b0;
      op_q    <= OP_AND;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
      op_q    <= op_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign busy      = state_q == BUSY;
  assign out_valid = state_q == DONE;
  assign aluresult = res_q;
  assign zero      = res_q == '0;
  assign divzero   = dz_q;
endmodule

// File: doc/alu_md.md
ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand/result width in bits (legal range 4..64).
REQ-002 Port clk SHALL be an input, 1 bit wide, and SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset SHALL be an input, 1 bit wide, and SHALL be a synchronous, active-high reset.
REQ-004 Port in_valid SHALL be an input, 1 bit wide, indicating that an operation request is present.
REQ-005 Port in_ready SHALL be an output, 1 bit wide, indicating the block can accept a request.
REQ-006 Port srca SHALL be an input, WIDTH bits wide, carrying operand A.
REQ-007 Port srcb SHALL be an input, WIDTH bits wide, carrying operand B.
REQ-008 Port aluctrl SHALL be an input, 3 bits wide, carrying the operation select.
REQ-009 Port out_valid SHALL be an output, 1 bit wide, indicating the result is valid.
REQ-010 Port out_ready SHALL be an input, 1 bit wide, indicating the consumer accepts the result.
REQ-011 Port aluresult SHALL be an output, WIDTH bits wide, carrying the result.
REQ-012 Port zero SHALL be an output, 1 bit wide, equal to 1 when aluresult is all zeros, for every operation.
REQ-013 Port divzero SHALL be an output, 1 bit wide, set when a DIVU/REMU request had srcb==0.
REQ-014 Port busy SHALL be an output, 1 bit wide, equal to 1 while an iterative operation is in progress.

Function
REQ-015 aluctrl encoding SHALL be:
- 000 AND
- 001 OR
- 010 ADD
- 110 SUB
- 111 SLT (unsigned compare, result 1 or 0)
- 011 MULU (low WIDTH bits of the product)
- 100 DIVU (quotient)
- 101 REMU (remainder)
REQ-016 The FSM SHALL have states IDLE, BUSY and DONE, with in_ready=1 only in IDLE.
REQ-017 A request SHALL be accepted on the clock edge where in_valid&&in_ready, and srca/srcb/aluctrl SHALL be captured at that edge.
REQ-018 Single-cycle ops (AND/OR/ADD/SUB/SLT) SHALL transition IDLE->DONE, giving out_valid on the cycle after acceptance (latency 1).
REQ-019 MULU SHALL use iterative shift-add, one bit per cycle: IDLE->BUSY for exactly WIDTH cycles, then BUSY->DONE; out_valid SHALL assert WIDTH+1 cycles after acceptance.
REQ-020 DIVU/REMU SHALL use iterative restoring division, one bit per cycle, with the same WIDTH+1 latency as MULU.
REQ-021 For DIVU/REMU with srcb==0, the block SHALL go IDLE->DONE at latency 1 with quotient all-ones, remainder = srca, and divzero=1.
REQ-022 In DONE, aluresult, zero and divzero SHALL hold stable while out_valid=1 && out_ready=0.
REQ-023 The transition DONE->IDLE SHALL occur on out_valid&&out_ready; there SHALL be no back-to-back acceptance in the same cycle (in_ready=0 in DONE).
REQ-024 ADD, SUB and MULU SHALL wrap modulo 2^WIDTH, with no overflow flag.
REQ-025 Input changes while in BUSY or DONE SHALL have no effect.
REQ-026 Undefined behaviour SHALL not exist: every 3-bit aluctrl code is defined, and no X SHALL be driven on outputs.

Reset
REQ-027 When reset=1 at a clock edge, the state SHALL become IDLE, out_valid=0, aluresult=0, divzero=0, busy=0, the iteration counter SHALL be 0, and in_ready SHALL be 1 from the following cycle; zero SHALL follow from aluresult (1 after reset).
REQ-028 Reset asserted during BUSY or DONE SHALL abort the operation; no out_valid SHALL follow for the aborted request.

Structure
REQ-029 Package alu_pkg SHALL hold the aluctrl code constants and the FSM state enum.
REQ-030 The iterative datapath SHALL be one submodule, alu_muldiv_iter (start, op, operands, done, product/quotient/remainder), parameterised by WIDTH and containing the bit counter.
REQ-031 Top-level alu_md SHALL contain the FSM, the single-cycle ops and the output registers.

Verification
REQ-032 ADD with srca=0xFFFFFFFF, srcb=1, WIDTH=32 -> out_valid at cycle +1, aluresult=0, zero=1.
REQ-033 MULU with srca=0x0001_0003, srcb=0x0001_0005 -> out_valid at cycle +33, aluresult=0x0008_000F, busy=1 for cycles +1..+32.
REQ-034 DIVU with 100, 7, then REMU with 100, 7 -> aluresult 14, then 2, each at latency 33, divzero=0.
REQ-035 DIVU with srcb=0, srca=0x1234 -> out_valid at +1, aluresult=0xFFFFFFFF, divzero=1; REMU with the same operands -> aluresult=0x1234.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result stable, in_ready=0, a new in_valid is ignored; releasing out_ready -> IDLE next cycle.
REQ-037 Assert reset at cycle +10 of a MULU -> IDLE next cycle, out_valid never asserts, a following SUB 5-7 returns 0xFFFFFFFE.
